// File: rtl/program_ram_loader.sv
// Writable program store with a byte-stream loader.
// A host streams bytes in over a valid/ready handshake. Byte pairs are packed
// high byte first into instructions and written to addresses 0 .. DEPTH-1.
// The core reads instructions combinationally and must wait while cpu_hold is high.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no load active; memory is stable for the core
// HI    | waiting for the high byte of the current word
// LO    | waiting for the low byte of the current word
// WR    | writing {hi, lo} to mem[ptr]; no byte is accepted in this cycle
// DONE  | every word has been written; load_done is high
module program_ram_loader #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] instruction,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic              wr_en;

    // Memory is not touched by reset; it starts as zeros at power-up.
    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

    // Next-state logic; abort overrides every other input in every state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wr_en   = 1'b0;
        if (load_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state_d = S_HI;
                        ptr_d   = '0;
                        count_d = '0;
                    end
                end
                S_HI: begin
                    if (byte_valid) begin
                        hi_d    = byte_data;
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    if (byte_valid) begin
                        lo_d    = byte_data;
                        state_d = S_WR;
                    end
                end
                S_WR: begin
                    wr_en   = 1'b1;
                    count_d = count_q + (ADDR_W + 1)'(1);
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = S_HI;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Word write at the end of the WR cycle; a reset in that cycle suppresses it.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[ptr_q] <= {hi_q, lo_q};
        end
    end

    assign byte_ready  = (state_q == S_HI) || (state_q == S_LO);
    assign cpu_hold    = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WR);
    assign load_done   = (state_q == S_DONE);
    assign word_count  = count_q;
    assign instruction = mem_q[address];

endmodule

// File: tb/tb_program_ram_loader.sv
// Directed bench for program_ram_loader with a write scoreboard and a
// reference memory image.
module tb_program_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [3:0]  address;
    logic [15:0] instruction;
    logic        cpu_hold;
    logic        load_done;
    logic [4:0]  word_count;

    program_ram_loader #(.ADDR_W(4), .WORD_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_abort  (load_abort),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .address     (address),
        .instruction (instruction),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] exp_mem [16];
    logic        hold_chk = 1'b0;
    int          start_cyc;
    int          done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte, optionally after an idle gap, and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (hold_chk) chk("hold_in_gap", cpu_hold, 1);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        total++;
        assert (n < 50) else begin
            bad++;
            $error("FAIL ready_timeout observed=%0d expected=<50", n);
        end
        tick();
    endtask

    task automatic send_word(input logic [3:0] a, input logic [15:0] w, input int gap);
        wr_t e;
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
        e.a = a;
        e.d = w;
        sb.push_back(e);
    endtask

    task automatic drain();
        wr_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            exp_mem[e.a] = e.d;
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            #1;
            chk(tag, instruction, exp_mem[i]);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic wait_done();
        int n;
        byte_valid = 1'b0;
        n = 0;
        while (!load_done && n < 20) begin
            tick();
            n++;
        end
        done_cyc = cyc;
    endtask

    function automatic logic [15:0] pattern(input int i);
        if (i == 0) return 16'h1203;
        if (i == 1) return 16'h1407;
        if (i == 2) return 16'h2280;
        if (i == 15) return 16'hF400;
        return 16'hF200;
    endfunction

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_abort = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        address    = 4'h0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and power-up memory
        chk("rst_ready", byte_ready, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_count", word_count, 0);
        check_mem("rst_mem");

        // Full load with valid held high
        start_load();
        chk("start_ready", byte_ready, 1);
        chk("start_hold", cpu_hold, 1);
        for (int i = 0; i < 16; i++) send_word(4'(i), pattern(i), 0);
        chk("pre_done", load_done, 0);
        wait_done();
        chk("full_latency", done_cyc - start_cyc, 48);
        chk("full_done", load_done, 1);
        chk("full_hold_fall", cpu_hold, 0);
        chk("full_count", word_count, 16);
        chk("done_ready", byte_ready, 0);
        drain();
        check_mem("full_mem");

        // Reload from DONE with 0xAAAA
        start_load();
        chk("reload_done_drop", load_done, 0);
        chk("reload_count_clr", word_count, 0);
        for (int i = 0; i < 16; i++) send_word(4'(i), 16'hAAAA, 0);
        wait_done();
        chk("reload_latency", done_cyc - start_cyc, 48);
        chk("reload_done", load_done, 1);
        drain();
        check_mem("reload_mem");

        // Gapped valid with a mid-load start that must be ignored
        start_load();
        hold_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_word(4'(i), pattern(i), int'($urandom_range(3, 0)));
            if (i == 5) begin
                byte_valid = 1'b0;
                load_start = 1'b1;
                tick();
                chk("midstart_wr_count", word_count, 6);
                tick();
                load_start = 1'b0;
                chk("midstart_hi_count", word_count, 6);
                chk("midstart_hold", cpu_hold, 1);
            end
        end
        hold_chk = 1'b0;
        wait_done();
        chk("gap_done", load_done, 1);
        chk("gap_count", word_count, 16);
        drain();
        check_mem("gap_mem");

        // Abort after 2 words plus a high byte
        start_load();
        send_word(4'd0, 16'h5A01, 0);
        send_word(4'd1, 16'h5A02, 0);
        send_byte(8'h77, 0);
        byte_valid = 1'b0;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        chk("abort_count", word_count, 2);
        chk("abort_ready", byte_ready, 0);
        chk("abort_hold", cpu_hold, 0);
        chk("abort_done", load_done, 0);
        drain();
        check_mem("abort_mem");

        // Restart from IDLE begins at address 0
        start_load();
        chk("restart_count", word_count, 0);
        chk("restart_ready", byte_ready, 1);
        send_word(4'd0, 16'h3C3C, 1);
        byte_valid = 1'b0;
        tick();
        chk("restart_count1", word_count, 1);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        drain();
        check_mem("restart_mem");

        // Reset while in LO leaves memory intact
        start_load();
        send_byte(8'h99, 0);
        byte_valid = 1'b0;
        chk("lo_ready", byte_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstlo_ready", byte_ready, 0);
        chk("rstlo_hold", cpu_hold, 0);
        chk("rstlo_done", load_done, 0);
        chk("rstlo_count", word_count, 0);
        check_mem("rstlo_mem");

        // Abort together with start in IDLE stays in IDLE
        load_abort = 1'b1;
        load_start = 1'b1;
        tick();
        load_abort = 1'b0;
        load_start = 1'b0;
        chk("abortstart_ready", byte_ready, 0);
        chk("abortstart_hold", cpu_hold, 0);
        tick();
        chk("abortstart_idle", cpu_hold, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
